// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO/memory controller and anything that decodes its address map.
package mmio_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    IO_WR = 1'b1
  } state_t;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'h2000;
  localparam int          CH_W            = 4;

endpackage

// File: rtl/mmio_decode.sv
// Address decode: flags the MMIO window [IO_BASE, IO_BASE+NUM_CH) and yields the channel index.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int            AW      = 16,
  parameter int            NUM_CH  = 4,
  parameter logic [AW-1:0] IO_BASE = AW'(IO_BASE_DEFAULT)
) (
  input  logic [AW-1:0]   addr,
  output logic            is_io,
  output logic [CH_W-1:0] ch
);

  // One extra bit so addresses below IO_BASE cannot wrap into the window.
  logic [AW:0] off;

  assign off   = {1'b0, addr} - {1'b0, IO_BASE};
  assign is_io = (addr >= IO_BASE) && (off < (AW+1)'(NUM_CH));
  assign ch    = off[CH_W-1:0];

endmodule

// File: rtl/mmio_mem_controller.sv
// CPU data/instruction port controller: main block RAM, registered read return,
// stalled posted writes to NUM_CH MMIO channels with timeout and sticky error.
//
// state | meaning
// IDLE  | accept CPU accesses; memory ops and IO reads complete without stall
// IO_WR | io_wr_valid held on latched channel until ready or timeout; CPU stalled
module mmio_mem_controller
  import mmio_pkg::*;
#(
  parameter int            DW      = 16,
  parameter int            AW      = 16,
  parameter int            IW      = 18,
  parameter int            NUM_CH  = 4,
  parameter logic [AW-1:0] IO_BASE = AW'(IO_BASE_DEFAULT),
  parameter int            TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_wr_en,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_rvalid,
  output logic                 cpu_stall,
  input  logic [AW-1:0]        cpu_iaddr,
  output logic [IW-1:0]        cpu_instr,
  output logic [AW-1:0]        mem_iaddr,
  input  logic [IW-1:0]        mem_instr,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_wr_en,
  input  logic [DW-1:0]        mem_rdata,
  output logic [DW-1:0]        io_wdata,
  output logic [NUM_CH-1:0]    io_wr_valid,
  input  logic [NUM_CH-1:0]    io_wr_ready,
  input  logic [NUM_CH*DW-1:0] io_status,
  output logic                 io_err,
  output logic [CH_W-1:0]      io_err_ch
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("mmio_mem_controller: NUM_CH must be 1..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mmio_mem_controller: TIMEOUT must be >= 1");
  end
  if (64'(IO_BASE) + 64'(NUM_CH) > (64'd1 << AW)) begin : g_bad_io_base
    $error("mmio_mem_controller: MMIO window wraps past the address space");
  end

  state_t          state, state_next;
  logic            is_io;
  logic [CH_W-1:0] ch, ch_q;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   wdata_q, rdata_q, status_sel;
  logic            rvalid_q, rd_mem_q, retire_q;
  logic            idle, accept_rd, accept_io_wr, drop;

  mmio_decode #(.AW(AW), .NUM_CH(NUM_CH), .IO_BASE(IO_BASE)) u_decode (
    .addr  (cpu_addr),
    .is_io (is_io),
    .ch    (ch)
  );

  assign cpu_instr = mem_instr;
  assign mem_iaddr = cpu_iaddr;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign io_wdata  = wdata_q;

  // The cycle after IO_WR carries the CPU's still-held write; it retires there, not re-issued.
  assign idle         = (state == IDLE) && !retire_q;
  assign accept_rd    = idle && cpu_req && !cpu_wr_en;
  assign accept_io_wr = idle && cpu_req && cpu_wr_en && is_io;
  assign mem_wr_en    = idle && cpu_req && cpu_wr_en && !is_io;

  assign cpu_stall  = (state == IO_WR) || accept_io_wr;
  assign cpu_rvalid = rvalid_q && !cpu_stall;
  assign cpu_rdata  = rd_mem_q ? mem_rdata : rdata_q;

  always_comb begin
    state_next  = state;
    io_wr_valid = '0;
    status_sel  = '0;
    drop        = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CH_W'(k)) status_sel = io_status[k*DW +: DW];
      if (state == IO_WR && ch_q == CH_W'(k)) io_wr_valid[k] = 1'b1;
    end
    case (state)
      IDLE: if (accept_io_wr) state_next = IO_WR;
      IO_WR: begin
        if (|(io_wr_ready & io_wr_valid)) begin
          state_next = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_next = IDLE;
          drop       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ch_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rd_mem_q  <= 1'b0;
      retire_q  <= 1'b0;
      io_err    <= 1'b0;
      io_err_ch <= '0;
    end else begin
      state    <= state_next;
      retire_q <= (state == IO_WR) && (state_next == IDLE);
      cnt      <= (state == IO_WR) ? cnt + CW'(1) : '0;
      if (accept_io_wr) begin
        ch_q    <= ch;
        wdata_q <= cpu_wdata;
      end
      if (drop) begin
        io_err <= 1'b1;
        if (!io_err) io_err_ch <= ch_q;
      end
      // A read return colliding with a write stall is parked until the stall clears.
      if (rvalid_q && cpu_stall) begin
        rdata_q  <= cpu_rdata;
        rd_mem_q <= 1'b0;
      end else begin
        rvalid_q <= accept_rd;
        rd_mem_q <= accept_rd && !is_io;
        if (accept_rd && is_io) rdata_q <= status_sel;
      end
    end
  end

endmodule

// File: tb/tb_mmio_mem_controller.sv
// Self-checking bench: read-return scoreboard plus directed IO write handshake/timeout checks.
module tb_mmio_mem_controller;

  localparam int DW = 16, AW = 16, IW = 18, NUM_CH = 4, TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_wr_en;
  logic [AW-1:0]     cpu_addr, cpu_iaddr, mem_iaddr, mem_addr;
  logic [DW-1:0]     cpu_wdata, cpu_rdata, mem_wdata, mem_rdata, io_wdata;
  logic              cpu_rvalid, cpu_stall, mem_wr_en, io_err;
  logic [IW-1:0]     cpu_instr, mem_instr;
  logic [NUM_CH-1:0] io_wr_valid, io_wr_ready;
  logic [NUM_CH*DW-1:0] io_status;
  logic [3:0]        io_err_ch;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram[256];
  logic [DW-1:0] exp_mem[256];

  mmio_mem_controller #(
    .DW(DW), .AW(AW), .IW(IW), .NUM_CH(NUM_CH), .IO_BASE(16'h2000), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .cpu_iaddr(cpu_iaddr), .cpu_instr(cpu_instr), .mem_iaddr(mem_iaddr), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
    .io_wdata(io_wdata), .io_wr_valid(io_wr_valid), .io_wr_ready(io_wr_ready),
    .io_status(io_status), .io_err(io_err), .io_err_ch(io_err_ch)
  );

  always #5 clk = ~clk;

  // Synchronous block RAM model, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && cpu_rvalid) begin
      check_val("rvalid_vs_stall", 32'(cpu_stall), 32'd0);
      if (exp_q.size() == 0) check_val("rvalid_spurious", 32'd1, 32'd0);
      else check_val("rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle;
    cpu_req = 1'b0;
    cpu_wr_en = 1'b0;
    tick();
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = addr;
    #1;
    check_val("rd_stall", 32'(cpu_stall), 32'd0);
    check_val("rd_mem_wr_en", 32'(mem_wr_en), 32'd0);
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic cpu_mem_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = addr; cpu_wdata = data;
    #1;
    check_val("mw_wr_en", 32'(mem_wr_en), 32'd1);
    check_val("mw_wdata", 32'(mem_wdata), 32'(data));
    check_val("mw_io_valid", 32'(io_wr_valid), 32'd0);
    check_val("mw_stall", 32'(cpu_stall), 32'd0);
    exp_mem[addr[7:0]] = data;
    tick();
  endtask

  // ready_after = IO_WR cycle on which the channel accepts; 0 = never (timeout).
  task automatic cpu_io_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input int ready_after, input logic [NUM_CH-1:0] noise);
    int nvalid = 0;
    logic [NUM_CH-1:0] onehot;
    logic done = 1'b0;
    onehot = NUM_CH'(1) << (addr - 16'h2000);
    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = addr; cpu_wdata = data;
    io_wr_ready = noise & ~onehot;
    #1;
    check_val("iow_req_stall", 32'(cpu_stall), 32'd1);
    check_val("iow_req_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check_val("iow_req_valid", 32'(io_wr_valid), 32'd0);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (io_wr_valid != '0) begin
        nvalid++;
        check_val("iow_valid", 32'(io_wr_valid), 32'(onehot));
        check_val("iow_wdata", 32'(io_wdata), 32'(data));
        check_val("iow_stall", 32'(cpu_stall), 32'd1);
        if (nvalid == ready_after) io_wr_ready = io_wr_ready | onehot;
      end else begin
        check_val("iow_retire_stall", 32'(cpu_stall), 32'd0);
        check_val("iow_retire_mem_wr_en", 32'(mem_wr_en), 32'd0);
        io_wr_ready = '0;
        done = 1'b1;
      end
    end
    if (!done) check_val("iow_bound", 32'd0, 32'd1);
    check_val("iow_nvalid", 32'(nvalid), 32'(ready_after != 0 ? ready_after : TIMEOUT));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 16'h0101) ^ 16'h3C00;
    ram[8'h10] = 16'hBEEF;
    ram[8'h04] = 16'h5A5A;
    for (int i = 0; i < 256; i++) exp_mem[i] = ram[i];
    reset = 1'b1; cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_iaddr = '0; mem_instr = '0; io_wr_ready = '0;
    io_status = {16'h0001, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_val("rst_stall", 32'(cpu_stall), 32'd0);
    check_val("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check_val("rst_rdata", 32'(cpu_rdata), 32'd0);
    check_val("rst_io_valid", 32'(io_wr_valid), 32'd0);
    check_val("rst_io_wdata", 32'(io_wdata), 32'd0);
    check_val("rst_io_err", 32'(io_err), 32'd0);
    check_val("rst_io_err_ch", 32'(io_err_ch), 32'd0);

    cpu_iaddr = 16'h1234; mem_instr = 18'h2ABCD;
    #1;
    check_val("instr", 32'(cpu_instr), 32'h2ABCD);
    check_val("iaddr", 32'(mem_iaddr), 32'h1234);
    tick();

    cpu_read(16'h0010, 16'hBEEF);
    cpu_idle();
    cpu_mem_write(16'h0020, 16'h1234);
    cpu_read(16'h0010, exp_mem[8'h10]);
    cpu_read(16'h0020, exp_mem[8'h20]);

    cpu_read(16'h2003, 16'h0001);
    io_status[3*DW +: DW] = 16'hFFFF;
    cpu_read(16'h2000, 16'hA0A0);
    io_status[3*DW +: DW] = 16'h0001;
    cpu_read(16'h2004, exp_mem[8'h04]);
    cpu_read(16'h1FFF, exp_mem[8'hFF]);
    cpu_idle();

    cpu_io_write(16'h2002, 16'h00AA, 3, '0);
    check_val("io_err_clean", 32'(io_err), 32'd0);
    cpu_io_write(16'h2000, 16'h5555, 1, '0);
    cpu_read(16'h0010, exp_mem[8'h10]);
    cpu_io_write(16'h2003, 16'h7777, 2, 4'b0111);
    cpu_io_write(16'h2001, 16'h0F0F, 0, 4'b1101);
    check_val("to1_err", 32'(io_err), 32'd1);
    check_val("to1_err_ch", 32'(io_err_ch), 32'd1);
    cpu_io_write(16'h2003, 16'hF0F0, 0, '0);
    check_val("to2_err", 32'(io_err), 32'd1);
    check_val("to2_err_ch_kept", 32'(io_err_ch), 32'd1);
    cpu_read(16'h2001, 16'hB1B1);
    cpu_idle();

    cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 16'h9999;
    tick();
    tick();
    check_val("mid_valid2", 32'(io_wr_valid), 32'b0001);
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    check_val("mid_rst_valid", 32'(io_wr_valid), 32'd0);
    check_val("mid_rst_stall", 32'(cpu_stall), 32'd0);
    check_val("mid_rst_io_err", 32'(io_err), 32'd0);
    check_val("mid_rst_err_ch", 32'(io_err_ch), 32'd0);
    reset = 1'b0;
    tick();
    check_val("post_rst_valid", 32'(io_wr_valid), 32'd0);
    cpu_read(16'h0020, exp_mem[8'h20]);
    cpu_idle();
    cpu_idle();
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_mem_controller.md
Name: mmio_mem_controller

Overview:
- Parametrised successor to the CPU-side data/instruction memory controller. It decodes CPU data accesses to main block RAM or to NUM_CH memory-mapped I/O channels.
- Adds a registered read-return path, stall-based posted-write handshake per I/O channel, and a timeout with a sticky error flag.
- Sits between the CPU core, the dual-port main block RAM and the peripheral registers (LCD, PRAM queue, etc.).
- The instruction port is a combinational pass-through.

Parameters:
- DW, 16, data width.
- AW, 16, address width.
- IW, 18, instruction width.
- NUM_CH, 4, number of MMIO channels (1..16).
- IO_BASE, 16'h2000, first MMIO address; channel k is at IO_BASE+k.
- TIMEOUT, 15, max cycles to wait for io_wr_ready before dropping a write (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  data access request this cycle.
- cpu_wr_en  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  AW  data address.
- cpu_wdata  in  DW  write data.
- cpu_rdata  out  DW  read data; valid when cpu_rvalid.
- cpu_rvalid  out  1  one-cycle pulse returning read data.
- cpu_stall  out  1  CPU must hold its request and pipeline.
- cpu_iaddr  in  AW  instruction address.
- cpu_instr  out  IW  instruction word.
- mem_iaddr  out  AW  to block RAM instruction port.
- mem_instr  in  IW  from block RAM instruction port.
- mem_addr  out  AW  block RAM data address.
- mem_wdata  out  DW  block RAM write data.
- mem_wr_en  out  1  block RAM write enable.
- mem_rdata  in  DW  block RAM read data (synchronous, 1-cycle latency).
- io_wdata  out  DW  held write data for the active channel.
- io_wr_valid  out  NUM_CH  one-hot write valid.
- io_wr_ready  in  NUM_CH  per-channel accept.
- io_status  in  NUM_CH*DW  channel k status at bits [k*DW +: DW].
- io_err  out  1  sticky timeout flag.
- io_err_ch  out  4  channel index of the first timeout.

Behaviour:
- Reset values:
  - cpu_rvalid=0, cpu_rdata=0, cpu_stall=0.
  - io_wr_valid=0, io_wdata=0.
  - io_err=0, io_err_ch=0.
  - FSM in IDLE, timeout counter=0.
  - Reset mid-write drops the pending write with no further valid.
- Decode (combinational on cpu_addr): is_io when IO_BASE <= addr < IO_BASE+NUM_CH; ch = addr-IO_BASE, truncated to 4 bits. All other addresses go to main memory.
- Instruction path: cpu_instr=mem_instr and mem_iaddr=cpu_iaddr, combinational, no stall interaction.
- mem_addr=cpu_addr and mem_wdata=cpu_wdata always.
- mem_wr_en = cpu_req & cpu_wr_en & ~is_io & state==IDLE.
- FSM states: IDLE, IO_WR.
  - IDLE, memory read: cpu_rvalid=1 next cycle, cpu_rdata=mem_rdata. Latency 1, no stall.
  - IDLE, IO read: next cycle cpu_rvalid=1, cpu_rdata=io_status[ch], sampled at the request edge and registered. Latency 1.
  - IDLE, memory write: completes in the same cycle; no rvalid.
  - IDLE, IO write: latch ch and cpu_wdata, then go to IO_WR. cpu_stall is asserted combinationally in the request cycle.
  - IO_WR: io_wr_valid[ch]=1 and io_wdata held. cpu_stall=1.
    - Counter increments each cycle.
    - On io_wr_ready[ch]=1: handshake completes that cycle; next state IDLE, stall drops next cycle.
    - If the counter reaches TIMEOUT without ready: drop the write, go to IDLE.
    - On timeout, set io_err=1; set io_err_ch=ch only if io_err was 0 (first error kept).
- Ready arriving on the first IO_WR cycle gives 1 stall cycle plus the request cycle.
- io_wr_ready on non-selected channels is ignored. Valid never deasserts before ready or timeout.
- CPU requests presented while cpu_stall=1 are not acted on; the CPU holds them, and they are processed in IDLE.
- cpu_rvalid is never asserted in the same cycle as cpu_stall caused by a new write.
- Address IO_BASE+NUM_CH and above is main memory. Wrap of IO_BASE+NUM_CH past 2^AW is disallowed; enforce with an elaboration-time check.
- io_err is cleared only by reset.

Decomposition:
- Package mmio_pkg: state encoding (IDLE, IO_WR), default IO_BASE, and a ch index width constant (4).
- One natural sub-module: mmio_decode, combinational (addr -> is_io, ch), reusable by the bus monitor.
- FSM, counter and read-return registers stay in the top.

Test Plan:
- Memory read: cpu_req=1, wr=0, addr=16'h0010, mem_rdata=16'hBEEF -> next cycle rvalid=1, rdata=BEEF, stall=0 throughout.
- Memory write: addr=16'h0020, wdata=16'h1234 -> mem_wr_en=1 the same cycle; io_wr_valid=0; no stall.
- IO write with ready after 3 cycles to ch2 (addr 16'h2002, wdata 16'h00AA) -> io_wr_valid=4'b0100 for 3 cycles, io_wdata=00AA, stall high, stall low on the cycle after ready.
- IO write timeout: ch1, ready never asserted, TIMEOUT=15 -> valid held exactly 15 cycles, then dropped; io_err=1, io_err_ch=1. A second timeout on ch3 leaves io_err_ch=1.
- IO read: io_status ch3=16'h0001 (queue full), addr 16'h2003 -> next cycle rvalid=1, rdata=0001. Address 16'h2004 (NUM_CH=4) reads from main memory.
- Reset mid IO_WR: reset=1 during the 2nd valid cycle -> next cycle io_wr_valid=0, stall=0, FSM IDLE, io_err=0.
